// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, reset PC,
// instruction field positions and the jump-register funct code.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'b00,
        ST_FULL  = 2'b01,
        ST_DRAIN = 2'b10
    } fetchState_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    localparam logic [5:0] FUNCT_JR = 6'b001000;

    function automatic logic isMisaligned(input logic [1:0] lowBits);
        return (lowBits != 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the fetch unit's memory, decode and redirect signals.
// master = fetch unit, slave = memory/decode side.
interface instruction_fetch_unit_if;
    import fetch_pkg::*;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [5:0]  if_op;
    logic [5:0]  if_funct;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        misaligned;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output if_valid, if_instr, if_pc, if_op, if_funct,
        input  if_ready,
        input  redirect_valid, redirect_target,
        output misaligned
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  if_valid, if_instr, if_pc, if_op, if_funct,
        output if_ready,
        output redirect_valid, redirect_target,
        input  misaligned
    );

endinterface

// File: rtl/fetch_out_reg.sv
// Valid/ready output register for instruction + pc, with a one-entry skid that
// absorbs a word returned while decode is stalled.
module fetch_out_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] loadInstr,
    input  logic [31:0] loadPc,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    logic        validR;
    logic [31:0] instrR;
    logic [31:0] pcR;
    logic        skidValidR;
    logic [31:0] skidInstrR;
    logic [31:0] skidPcR;

    // Load / hold / flush of the presented entry and the skid entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validR     <= 1'b0;
            instrR     <= 32'h0000_0000;
            pcR        <= 32'h0000_0000;
            skidValidR <= 1'b0;
            skidInstrR <= 32'h0000_0000;
            skidPcR    <= 32'h0000_0000;
        end else if (flush) begin
            validR     <= 1'b0;
            skidValidR <= 1'b0;
        end else if (skidValidR) begin
            if (ready) begin
                instrR     <= skidInstrR;
                pcR        <= skidPcR;
                validR     <= 1'b1;
                skidValidR <= 1'b0;
            end
        end else if (load) begin
            if (!validR || ready) begin
                instrR <= loadInstr;
                pcR    <= loadPc;
                validR <= 1'b1;
            end else begin
                skidInstrR <= loadInstr;
                skidPcR    <= loadPc;
                skidValidR <= 1'b1;
            end
        end else if (ready) begin
            validR <= 1'b0;
        end
    end

    assign valid = validR;
    assign instr = instrR;
    assign pc    = pcR;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues memory requests, presents fetched
// words to decode and handles jump-register redirects from decode.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);

    fetchState_e stateR;
    fetchState_e nextStateS;
    logic        reqR;
    logic [31:0] pcR;
    logic [31:0] nextPcS;
    logic [31:0] targetR;
    logic [31:0] nextTargetS;
    logic        misalignedR;
    logic        ackS;
    logic        loadS;
    logic [31:0] alignedTargetS;
    logic [31:0] ifInstrS;

    assign ackS           = bus.imem_ack & reqR;
    assign alignedTargetS = {bus.redirect_target[31:2], 2'b00};

    // Next-state, next-pc and pending-target selection; redirect overrides everything
    always_comb begin
        nextStateS  = stateR;
        nextPcS     = pcR;
        nextTargetS = targetR;
        loadS       = 1'b0;
        if (bus.redirect_valid) begin
            nextTargetS = alignedTargetS;
            // An outstanding request must complete at its original address first
            if (reqR && !bus.imem_ack) begin
                nextStateS = ST_DRAIN;
            end else begin
                nextStateS = ST_REQ;
                nextPcS    = alignedTargetS;
            end
        end else begin
            case (stateR)
                ST_REQ: begin
                    if (ackS) begin
                        loadS      = 1'b1;
                        nextPcS    = pcR + PC_STEP;
                        nextStateS = (bus.if_valid && !bus.if_ready) ? ST_FULL : ST_REQ;
                    end else begin
                        nextStateS = ST_REQ;
                    end
                end
                ST_FULL: begin
                    if (bus.if_ready) begin
                        nextStateS = ST_REQ;
                    end else begin
                        nextStateS = ST_FULL;
                    end
                end
                ST_DRAIN: begin
                    if (ackS) begin
                        nextStateS = ST_REQ;
                        nextPcS    = targetR;
                    end else begin
                        nextStateS = ST_DRAIN;
                    end
                end
                default: begin
                    nextStateS = ST_REQ;
                end
            endcase
        end
    end

    // FSM state, request strobe, pc, pending target and misalignment pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateR      <= ST_REQ;
            reqR        <= 1'b0;
            pcR         <= RESET_PC;
            targetR     <= RESET_PC;
            misalignedR <= 1'b0;
        end else begin
            stateR      <= nextStateS;
            reqR        <= (nextStateS != ST_FULL);
            pcR         <= nextPcS;
            targetR     <= nextTargetS;
            misalignedR <= bus.redirect_valid & isMisaligned(bus.redirect_target[1:0]);
        end
    end

    fetch_out_reg u_outReg (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect_valid),
        .load      (loadS),
        .loadInstr (bus.imem_rdata),
        .loadPc    (pcR),
        .ready     (bus.if_ready),
        .valid     (bus.if_valid),
        .instr     (ifInstrS),
        .pc        (bus.if_pc)
    );

    assign bus.if_instr   = ifInstrS;
    assign bus.if_op      = ifInstrS[OP_MSB:OP_LSB];
    assign bus.if_funct   = ifInstrS[FUNCT_MSB:FUNCT_LSB];
    assign bus.imem_req   = reqR;
    assign bus.imem_addr  = pcR;
    assign bus.misaligned = misalignedR;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed tables and sequences
// plus a randomized run checked by a transaction-level fetch-order model.
module tb_instruction_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   xfers  = 0;
    int   fixedWait = 0;
    logic ackEnable = 1'b1;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC (32'h0040_0000),
        .PC_STEP  (32'd4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc;
    } streamVec_t;

    typedef struct {
        logic [31:0] target;
        logic        expMis;
        logic [31:0] expAddr;
        logic [31:0] expNext;
    } redirVec_t;

    streamVec_t streamTbl [6];
    redirVec_t  redirTbl  [4];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] w;
        w = (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
        if (a[5:2] == 4'd0) w[5:0] = FUNCT_JR;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory: acks after fixedWait wait states (random 0..3 when negative)
    initial begin
        int   waitLeft;
        logic busy;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        waitLeft = 0;
        busy     = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || !bus.imem_req) begin
                bus.imem_ack = 1'b0;
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    waitLeft = (fixedWait >= 0) ? fixedWait : int'($urandom_range(0, 3));
                end
                if (waitLeft == 0 && ackEnable) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = memWord(bus.imem_addr);
                    busy = 1'b0;
                end else begin
                    bus.imem_ack = 1'b0;
                    if (waitLeft > 0) waitLeft--;
                end
            end
        end
    end

    // Reference model: delivered instructions follow the pc sequence from reset or last redirect
    initial begin
        logic [31:0] expPc, pAddr, pInstr, pPc, w;
        logic pReq, pAck, pValid, pReady, pRedir, pMis;
        expPc = 32'h0040_0000;
        pAddr = 32'h0; pInstr = 32'h0; pPc = 32'h0;
        pReq = 1'b0; pAck = 1'b0; pValid = 1'b0; pReady = 1'b0; pRedir = 1'b0; pMis = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                expPc = 32'h0040_0000;
                pReq = 1'b0; pAck = 1'b0; pValid = 1'b0; pReady = 1'b0; pRedir = 1'b0; pMis = 1'b0;
            end else begin
                if (pReq && !pAck) begin
                    chk("hold_req", bus.imem_req, 1);
                    chk("hold_addr", bus.imem_addr, pAddr);
                end
                chk("mis_pulse", bus.misaligned, pMis);
                if (pRedir) chk("flush_valid", bus.if_valid, 0);
                if (pValid && !pReady && !pRedir) begin
                    chk("stall_valid", bus.if_valid, 1);
                    chk("stall_instr", bus.if_instr, pInstr);
                    chk("stall_pc", bus.if_pc, pPc);
                end
                if (bus.redirect_valid) begin
                    expPc = {bus.redirect_target[31:2], 2'b00};
                end else if (bus.if_valid && bus.if_ready) begin
                    w = memWord(expPc);
                    chk("xfer_pc", bus.if_pc, expPc);
                    chk("xfer_instr", bus.if_instr, w);
                    chk("xfer_op", {26'd0, bus.if_op}, {26'd0, w[31:26]});
                    chk("xfer_funct", {26'd0, bus.if_funct}, {26'd0, w[5:0]});
                    expPc = expPc + 32'd4;
                    xfers++;
                end
                pReq   = bus.imem_req;
                pAck   = bus.imem_ack;
                pAddr  = bus.imem_addr;
                pValid = bus.if_valid;
                pReady = bus.if_ready;
                pInstr = bus.if_instr;
                pPc    = bus.if_pc;
                pRedir = bus.redirect_valid;
                pMis   = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
            end
        end
    end

    task automatic doReset(input int waitCfg, input logic ackCfg);
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.if_ready = 1'b1;
        fixedWait = waitCfg;
        ackEnable = ackCfg;
        repeat (2) @(negedge clk);
        #4;
        chk("rst_req", bus.imem_req, 0);
        chk("rst_valid", bus.if_valid, 0);
        chk("rst_instr", bus.if_instr, 0);
        chk("rst_pc", bus.if_pc, 0);
        chk("rst_mis", bus.misaligned, 0);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] heldInstr, heldPc;
        reset = 1'b1;
        bus.if_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'h0;

        streamTbl[0] = '{1'b1, 32'h0040_0000, 1'b0, 32'h0000_0000};
        streamTbl[1] = '{1'b1, 32'h0040_0004, 1'b1, 32'h0040_0000};
        streamTbl[2] = '{1'b1, 32'h0040_0008, 1'b1, 32'h0040_0004};
        streamTbl[3] = '{1'b1, 32'h0040_000C, 1'b1, 32'h0040_0008};
        streamTbl[4] = '{1'b1, 32'h0040_0010, 1'b1, 32'h0040_000C};
        streamTbl[5] = '{1'b1, 32'h0040_0014, 1'b1, 32'h0040_0010};

        redirTbl[0] = '{32'h0040_0102, 1'b1, 32'h0040_0100, 32'h0040_0104};
        redirTbl[1] = '{32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000};
        redirTbl[2] = '{32'h0040_0000, 1'b0, 32'h0040_0000, 32'h0040_0004};
        redirTbl[3] = '{32'h1234_5677, 1'b1, 32'h1234_5674, 32'h1234_5678};

        // Zero-wait streaming
        doReset(0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.if_ready = streamTbl[i].ready;
            #4;
            chk("stream_req", bus.imem_req, 1);
            chk("stream_addr", bus.imem_addr, streamTbl[i].expAddr);
            chk("stream_valid", bus.if_valid, streamTbl[i].expValid);
            if (streamTbl[i].expValid) chk("stream_pc", bus.if_pc, streamTbl[i].expPc);
        end

        // Three wait states
        doReset(3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #4;
            chk("ws_req", bus.imem_req, 1);
            chk("ws_addr", bus.imem_addr, 32'h0040_0000);
            chk("ws_valid", bus.if_valid, 0);
        end
        @(negedge clk); #4;
        chk("ws_pulse", bus.if_valid, 1);
        chk("ws_pc", bus.if_pc, 32'h0040_0000);
        chk("ws_next_addr", bus.imem_addr, 32'h0040_0004);
        @(negedge clk); #4;
        chk("ws_pulse_end", bus.if_valid, 0);

        // Decode stall for five cycles
        doReset(0, 1'b1);
        repeat (2) begin @(negedge clk); #4; end
        @(negedge clk);
        bus.if_ready = 1'b0;
        #4;
        chk("stall1_valid", bus.if_valid, 1);
        heldInstr = bus.if_instr;
        heldPc = bus.if_pc;
        chk("stall1_pc", heldPc, 32'h0040_0004);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk); #4;
            chk("stall_frozen_instr", bus.if_instr, heldInstr);
            chk("stall_frozen_pc", bus.if_pc, heldPc);
            chk("stall_req_low", bus.imem_req, 0);
        end
        @(negedge clk);
        bus.if_ready = 1'b1;
        #4;
        chk("resume_pc0", bus.if_pc, heldPc);
        @(negedge clk); #4;
        chk("resume_pc1", bus.if_pc, heldPc + 32'd4);
        @(negedge clk); #4;
        chk("resume_pc2", bus.if_pc, heldPc + 32'd8);

        // Redirect while a request is outstanding
        doReset(0, 1'b0);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0040_0100;
        #4;
        chk("drain_addr0", bus.imem_addr, 32'h0040_0000);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.redirect_valid = 1'b0;
            #4;
            chk("drain_req", bus.imem_req, 1);
            chk("drain_addr", bus.imem_addr, 32'h0040_0000);
            chk("drain_valid", bus.if_valid, 0);
        end
        ackEnable = 1'b1;
        @(negedge clk); #4;
        chk("drain_ack_addr", bus.imem_addr, 32'h0040_0000);
        chk("drain_ack_valid", bus.if_valid, 0);
        @(negedge clk); #4;
        chk("drain_new_addr", bus.imem_addr, 32'h0040_0100);
        chk("drain_discard", bus.if_valid, 0);
        @(negedge clk); #4;
        chk("drain_first_valid", bus.if_valid, 1);
        chk("drain_first_pc", bus.if_pc, 32'h0040_0100);

        // Redirect target table, including misalignment and pc wrap
        doReset(0, 1'b1);
        repeat (3) begin @(negedge clk); #4; end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.redirect_valid = 1'b1;
            bus.redirect_target = redirTbl[i].target;
            #4;
            @(negedge clk);
            bus.redirect_valid = 1'b0;
            #4;
            chk("redir_mis", bus.misaligned, redirTbl[i].expMis);
            chk("redir_addr", bus.imem_addr, redirTbl[i].expAddr);
            chk("redir_flush", bus.if_valid, 0);
            @(negedge clk); #4;
            chk("redir_mis_end", bus.misaligned, 0);
            chk("redir_valid", bus.if_valid, 1);
            chk("redir_pc", bus.if_pc, redirTbl[i].expAddr);
            chk("redir_next", bus.imem_addr, redirTbl[i].expNext);
        end

        // Randomized traffic against the reference model
        doReset(-1, 1'b1);
        xfers = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.if_ready = ($urandom_range(0, 9) < 7);
            bus.redirect_valid = ($urandom_range(0, 24) == 0);
            bus.redirect_target = ($urandom_range(0, 9) == 0) ?
                (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) :
                (32'h0040_0000 + 32'($urandom_range(0, 1023)));
        end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #4;
        chk("random_progress", (xfers > 100) ? 32'd1 : 32'd0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
